axis_pkt_gen: RTL and testbench

AXIS_PKT_GEN -- requirements
Module: axis_pkt_gen

---
 rtl/axis_pkg.sv | 23 ++
 rtl/axis_pkt_gen_if.sv | 28 ++
 rtl/axis_keep_gen.sv | 28 ++
 rtl/axis_pkt_gen.sv | 198 +++++++++++++++++++
 tb/tb_axis_pkt_gen.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkg.sv
// Shared types for the AXI-Stream packet generator.
// FSM encoding, pattern modes and beat-count helper.
package axis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic PAT_INC = 1'b0;
  localparam logic PAT_DEC = 1'b1;

  function automatic logic [15:0] beats_of(
    input logic [15:0] len,
    input int          w
  );
    logic [16:0] num;
    num = 17'(len) + 17'(w - 1);
    return 16'(num / 17'(w));
  endfunction

endpackage

// File: rtl/axis_pkt_gen_if.sv
// AXI-Stream channel bundle for the packet generator.
// Master drives payload, slave drives tready.
interface axis_pkt_gen_if #(
  parameter int TDATA_WIDTH = 4,
  parameter int TKEEP_WIDTH = 64
);
  logic                       tvalid;
  logic                       tready;
  logic [TDATA_WIDTH*8-1:0]   tdata;
  logic [TKEEP_WIDTH-1:0]     tkeep;
  logic                       tlast;

  modport master (
    output tvalid,
    output tdata,
    output tkeep,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tkeep,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_keep_gen.sv
// Byte-enable masks for full and final beats of a frame.
// Lanes at or above TDATA_WIDTH are always zero.
module axis_keep_gen #(
  parameter int TDATA_WIDTH = 4,
  parameter int TKEEP_WIDTH = 64
) (
  input  logic [15:0]            frame_len,
  output logic [TKEEP_WIDTH-1:0] keep_full,
  output logic [TKEEP_WIDTH-1:0] keep_last
);

  logic [15:0] rem;

  assign rem = frame_len % 16'(TDATA_WIDTH);

  // Set low lanes; last beat keeps only the remainder lanes.
  always_comb begin
    keep_full = '0;
    keep_last = '0;
    for (int i = 0; i < TKEEP_WIDTH; i++) begin
      if (i < TDATA_WIDTH) begin
        keep_full[i] = 1'b1;
        keep_last[i] = (rem == 16'd0) || (i < int'(rem));
      end
    end
  end

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: runs of fixed-length frames
// with an incrementing/decrementing data pattern.
module axis_pkt_gen
  import axis_pkg::*;
#(
  parameter int TDATA_WIDTH = 4,
  parameter int TKEEP_WIDTH = 64,
  parameter int IFG_CYCLES  = 2
) (
  input  logic                     m_axis_aclk,
  input  logic                     m_axis_aresetn,
  input  logic                     start,
  input  logic                     stop,
  input  logic [15:0]              frame_len,
  input  logic [15:0]              frame_count,
  input  logic [TDATA_WIDTH*8-1:0] seed,
  input  logic                     decr,
  axis_pkt_gen_if.master           m_axis,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              frames_sent
);

  localparam int DW = TDATA_WIDTH * 8;
  localparam logic [DW-1:0] ONE = DW'(1);
  localparam logic [15:0] GAP_LAST = 16'(IFG_CYCLES - 1);

  state_t state_q, state_d;

  logic [15:0]            len_q, len_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   decr_q, decr_d;
  logic                   stop_q, stop_d;
  logic [15:0]            beat_q, beat_d;
  logic [15:0]            gap_q, gap_d;
  logic [15:0]            fs_q, fs_d;
  logic [DW-1:0]          data_q, data_d;
  logic [TKEEP_WIDTH-1:0] keep_q, keep_d;
  logic                   last_q, last_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;

  logic [15:0]            len_sel;
  logic [15:0]            nb_sel;
  logic [15:0]            fs_inc;
  logic [TKEEP_WIDTH-1:0] keep_full;
  logic [TKEEP_WIDTH-1:0] keep_last;
  logic                   fire;
  logic                   stop_seen;

  assign len_sel   = (state_q == IDLE) ? frame_len : len_q;
  assign nb_sel    = beats_of(len_sel, TDATA_WIDTH);
  assign fs_inc    = fs_q + 16'd1;
  assign fire      = valid_q & m_axis.tready;
  assign stop_seen = stop_q | stop;

  axis_keep_gen #(
    .TDATA_WIDTH (TDATA_WIDTH),
    .TKEEP_WIDTH (TKEEP_WIDTH)
  ) u_keep (
    .frame_len (len_sel),
    .keep_full (keep_full),
    .keep_last (keep_last)
  );

  // State and all registered outputs.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      decr_q  <= PAT_INC;
      stop_q  <= 1'b0;
      beat_q  <= '0;
      gap_q   <= '0;
      fs_q    <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      decr_q  <= decr_d;
      stop_q  <= stop_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      fs_q    <= fs_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    decr_d  = decr_q;
    stop_d  = stop_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    fs_d    = fs_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          fs_d = '0;
          if (frame_len != 16'd0 && frame_count != 16'd0) begin
            state_d = SEND;
            len_d   = frame_len;
            cnt_d   = frame_count;
            decr_d  = decr;
            stop_d  = 1'b0;
            data_d  = seed;
            beat_d  = nb_sel;
            last_d  = (nb_sel == 16'd1);
            keep_d  = last_d ? keep_last : keep_full;
            valid_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SEND: begin
        stop_d = stop_seen;
        if (fire) begin
          data_d = (decr_q == PAT_DEC) ? data_q - ONE
                                       : data_q + ONE;
          if (last_q) begin
            fs_d = fs_inc;
            if (fs_inc == cnt_q || stop_seen) begin
              state_d = IDLE;
              valid_d = 1'b0;
              last_d  = 1'b0;
              stop_d  = 1'b0;
              done_d  = 1'b1;
            end else if (IFG_CYCLES == 0) begin
              beat_d = nb_sel;
              last_d = (nb_sel == 16'd1);
              keep_d = last_d ? keep_last : keep_full;
            end else begin
              state_d = GAP;
              valid_d = 1'b0;
              last_d  = 1'b0;
              gap_d   = GAP_LAST;
            end
          end else begin
            beat_d = beat_q - 16'd1;
            last_d = (beat_q == 16'd2);
            keep_d = last_d ? keep_last : keep_full;
          end
        end
      end
      GAP: begin
        stop_d = stop_seen;
        if (gap_q == 16'd0) begin
          if (stop_seen) begin
            state_d = IDLE;
            stop_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = SEND;
            beat_d  = nb_sel;
            last_d  = (nb_sel == 16'd1);
            keep_d  = last_d ? keep_last : keep_full;
            valid_d = 1'b1;
          end
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign m_axis.tvalid = valid_q;
  assign m_axis.tdata  = data_q;
  assign m_axis.tkeep  = keep_q;
  assign m_axis.tlast  = last_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign frames_sent   = fs_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Bench for axis_pkt_gen: random stimulus against a
// frame-list reference model.
module tb_axis_pkt_gen;

  localparam int W   = 4;
  localparam int KW  = 64;
  localparam int IFG = 2;
  localparam int DW  = W * 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          decr = 1'b0;
  logic [15:0]   frame_len = '0;
  logic [15:0]   frame_count = '0;
  logic [DW-1:0] seed = '0;
  logic          busy;
  logic          done;
  logic [15:0]   frames_sent;

  axis_pkt_gen_if #(.TDATA_WIDTH(W), .TKEEP_WIDTH(KW)) axis ();

  axis_pkt_gen #(
    .TDATA_WIDTH (W),
    .TKEEP_WIDTH (KW),
    .IFG_CYCLES  (IFG)
  ) dut (
    .m_axis_aclk    (clk),
    .m_axis_aresetn (rst_n),
    .start          (start),
    .stop           (stop),
    .frame_len      (frame_len),
    .frame_count    (frame_count),
    .seed           (seed),
    .decr           (decr),
    .m_axis         (axis),
    .busy           (busy),
    .done           (done),
    .frames_sent    (frames_sent)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] got_d[$];
  logic [KW-1:0] got_k[$];
  logic          got_l[$];
  logic [DW-1:0] exp_d[$];
  logic [KW-1:0] exp_k[$];
  logic          exp_l[$];
  int            gaps[$];
  int            stall_err;
  bit            done_seen;
  bit            first_valid;
  logic [15:0]   fs_done;

  // Expected beat list from frame length, count, seed, direction.
  task automatic build_model(input int len, input int cnt,
                             input logic [DW-1:0] sd, input bit dec);
    int nb;
    int r;
    int idx;
    logic [DW-1:0] step;
    logic [KW-1:0] k;
    nb = (len + W - 1) / W;
    r = len % W;
    idx = 0;
    exp_d.delete();
    exp_k.delete();
    exp_l.delete();
    for (int f = 0; f < cnt; f++) begin
      for (int b = 0; b < nb; b++) begin
        step = DW'(idx);
        exp_d.push_back(dec ? sd - step : sd + step);
        k = KW'(15);
        if (b == nb - 1 && r != 0) k = (KW'(1) << r) - KW'(1);
        exp_k.push_back(k);
        exp_l.push_back(b == nb - 1);
        idx++;
      end
    end
  endtask

  task automatic start_run(input int len, input int cnt,
                           input logic [DW-1:0] sd, input bit dec);
    @(negedge clk);
    frame_len = 16'(len);
    frame_count = 16'(cnt);
    seed = sd;
    decr = dec;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drive tready, record handshakes, gaps, stalls and done.
  task automatic collect(input int ready_pct, input int stop_beat,
                         input int max_cyc);
    bit prev_stall;
    bit in_gap;
    bit stop_done;
    int run;
    logic [DW-1:0] pd;
    logic [KW-1:0] pk;
    logic pl;
    got_d.delete();
    got_k.delete();
    got_l.delete();
    gaps.delete();
    stall_err = 0;
    done_seen = 0;
    fs_done = '0;
    prev_stall = 0;
    in_gap = 0;
    stop_done = 0;
    run = 0;
    pd = '0;
    pk = '0;
    pl = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      axis.tready = ($urandom_range(99) < ready_pct);
      stop = !stop_done && stop_beat > 0 && axis.tvalid === 1'b1
             && got_d.size() == stop_beat - 1;
      if (stop) stop_done = 1;
      if (c == 0) first_valid = (axis.tvalid === 1'b1);
      if (prev_stall && (axis.tvalid !== 1'b1 || axis.tdata !== pd ||
          axis.tkeep !== pk || axis.tlast !== pl))
        stall_err++;
      if (in_gap) begin
        if (axis.tvalid === 1'b0) run++;
        else begin
          gaps.push_back(run);
          in_gap = 0;
        end
      end
      if (axis.tvalid === 1'b1 && axis.tready === 1'b1) begin
        got_d.push_back(axis.tdata);
        got_k.push_back(axis.tkeep);
        got_l.push_back(axis.tlast);
        if (axis.tlast === 1'b1) begin
          in_gap = 1;
          run = 0;
        end
      end
      if (done === 1'b1) begin
        done_seen = 1;
        fs_done = frames_sent;
        break;
      end
      prev_stall = (axis.tvalid === 1'b1) && !axis.tready;
      pd = axis.tdata;
      pk = axis.tkeep;
      pl = axis.tlast;
      @(negedge clk);
    end
    stop = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp += 4;
    if (axis.tvalid !== 1'b0 || axis.tlast !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid_last: got %b%b want 00",
               axis.tvalid, axis.tlast);
    end
    if (axis.tdata !== '0 || axis.tkeep !== '0) begin
      n_err++;
      $display("FAIL reset_data_keep: got %h/%h want 0/0",
               axis.tdata, axis.tkeep);
    end
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy_done: got %b%b want 00", busy, done);
    end
    if (frames_sent !== 16'd0) begin
      n_err++;
      $display("FAIL reset_frames: got %0d want 0", frames_sent);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    start_run(10, 1, 32'd15, 1'b1);
    build_model(10, 1, 32'd15, 1'b1);
    collect(100, 0, 50);
    n_cmp++;
    if (!first_valid) begin
      n_err++;
      $display("FAIL single_first: got tvalid 0 want 1");
    end
    n_cmp++;
    if (got_d.size() != 3) begin
      n_err++;
      $display("FAIL single_beats: got %0d want 3", got_d.size());
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== exp_d[i] || got_k[i] !== exp_k[i] ||
          got_l[i] !== exp_l[i]) begin
        n_err++;
        $display("FAIL single_beat%0d: got %h/%h/%b want %h/%h/%b", i,
                 got_d[i], got_k[i], got_l[i],
                 exp_d[i], exp_k[i], exp_l[i]);
      end
    end
    n_cmp++;
    if (!done_seen || fs_done !== 16'd1) begin
      n_err++;
      $display("FAIL single_done: got done %0d fs %0d want 1 1",
               done_seen, fs_done);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_gaps();
    logic [DW-1:0] sd;
    sd = DW'($urandom);
    start_run(8, 3, sd, 1'b0);
    build_model(8, 3, sd, 1'b0);
    collect(100, 0, 100);
    n_cmp++;
    if (got_d.size() != 6) begin
      n_err++;
      $display("FAIL gaps_beats: got %0d want 6", got_d.size());
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== exp_d[i] || got_k[i] !== exp_k[i] ||
          got_l[i] !== exp_l[i]) begin
        n_err++;
        $display("FAIL gaps_beat%0d: got %h/%h/%b want %h/%h/%b", i,
                 got_d[i], got_k[i], got_l[i],
                 exp_d[i], exp_k[i], exp_l[i]);
      end
    end
    n_cmp++;
    if (gaps.size() != 2) begin
      n_err++;
      $display("FAIL gaps_count: got %0d want 2", gaps.size());
    end
    foreach (gaps[i]) begin
      n_cmp++;
      if (gaps[i] != IFG) begin
        n_err++;
        $display("FAIL gaps_len%0d: got %0d want %0d", i, gaps[i], IFG);
      end
    end
    n_cmp++;
    if (!done_seen || fs_done !== 16'd3) begin
      n_err++;
      $display("FAIL gaps_done: got done %0d fs %0d want 1 3",
               done_seen, fs_done);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] want[4];
    want[0] = 32'hFFFF_FFFE;
    want[1] = 32'hFFFF_FFFF;
    want[2] = 32'h0000_0000;
    want[3] = 32'h0000_0001;
    start_run(16, 1, 32'hFFFF_FFFE, 1'b0);
    collect(100, 0, 50);
    n_cmp++;
    if (got_d.size() != 4) begin
      n_err++;
      $display("FAIL wrap_beats: got %0d want 4", got_d.size());
    end
    for (int i = 0; i < got_d.size() && i < 4; i++) begin
      n_cmp++;
      if (got_d[i] !== want[i]) begin
        n_err++;
        $display("FAIL wrap_data%0d: got %h want %h", i, got_d[i], want[i]);
      end
    end
  endtask

  task automatic test_stall();
    int len;
    int cnt;
    bit dec;
    logic [DW-1:0] sd;
    for (int t = 0; t < 3; t++) begin
      len = $urandom_range(40, 1);
      cnt = $urandom_range(3, 1);
      dec = 1'($urandom_range(1));
      sd = DW'($urandom);
      start_run(len, cnt, sd, dec);
      build_model(len, cnt, sd, dec);
      collect(50, 0, 2000);
      n_cmp++;
      if (got_d.size() != exp_d.size()) begin
        n_err++;
        $display("FAIL stall_beats%0d: got %0d want %0d", t,
                 got_d.size(), exp_d.size());
      end
      for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
        n_cmp++;
        if (got_d[i] !== exp_d[i] || got_k[i] !== exp_k[i] ||
            got_l[i] !== exp_l[i]) begin
          n_err++;
          $display("FAIL stall_beat%0d_%0d: got %h/%h/%b want %h/%h/%b",
                   t, i, got_d[i], got_k[i], got_l[i],
                   exp_d[i], exp_k[i], exp_l[i]);
        end
      end
      n_cmp++;
      if (stall_err != 0) begin
        n_err++;
        $display("FAIL stall_hold%0d: got %0d changes want 0", t, stall_err);
      end
      n_cmp++;
      if (!done_seen || fs_done !== 16'(cnt)) begin
        n_err++;
        $display("FAIL stall_done%0d: got done %0d fs %0d want 1 %0d",
                 t, done_seen, fs_done, cnt);
      end
    end
  endtask

  task automatic test_stop();
    logic [DW-1:0] sd;
    sd = DW'($urandom);
    start_run(16, 5, sd, 1'b1);
    build_model(16, 1, sd, 1'b1);
    collect(100, 2, 200);
    n_cmp++;
    if (got_d.size() != 4) begin
      n_err++;
      $display("FAIL stop_beats: got %0d want 4", got_d.size());
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        n_err++;
        $display("FAIL stop_beat%0d: got %h/%b want %h/%b", i,
                 got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    n_cmp++;
    if (!done_seen || fs_done !== 16'd1) begin
      n_err++;
      $display("FAIL stop_done: got done %0d fs %0d want 1 1",
               done_seen, fs_done);
    end
  endtask

  task automatic test_reset_mid();
    int vcount;
    start_run(40, 3, DW'($urandom), 1'b0);
    axis.tready = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (axis.tvalid !== 1'b0 || axis.tlast !== 1'b0 ||
        axis.tdata !== '0 || axis.tkeep !== '0) begin
      n_err++;
      $display("FAIL rstmid_axis: got %b/%b/%h/%h want 0/0/0/0",
               axis.tvalid, axis.tlast, axis.tdata, axis.tkeep);
    end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || frames_sent !== 16'd0) begin
      n_err++;
      $display("FAIL rstmid_status: got %b/%b/%0d want 0/0/0",
               busy, done, frames_sent);
    end
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    repeat (4) begin
      @(negedge clk);
      if (axis.tvalid === 1'b1) vcount++;
    end
    n_cmp++;
    if (vcount != 0) begin
      n_err++;
      $display("FAIL rstmid_release: got %0d valid cycles want 0", vcount);
    end
    start_run(0, 3, DW'($urandom), 1'b0);
    n_cmp++;
    if (done !== 1'b1 || axis.tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL zero_len_done: got done %b tvalid %b want 1 0",
               done, axis.tvalid);
    end
    vcount = 0;
    repeat (4) begin
      @(negedge clk);
      if (axis.tvalid === 1'b1 || done === 1'b1 || busy === 1'b1)
        vcount++;
    end
    n_cmp++;
    if (vcount != 0) begin
      n_err++;
      $display("FAIL zero_len_quiet: got %0d active cycles want 0", vcount);
    end
    start_run(8, 0, DW'($urandom), 1'b0);
    n_cmp++;
    if (done !== 1'b1 || axis.tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL zero_cnt_done: got done %b tvalid %b want 1 0",
               done, axis.tvalid);
    end
  endtask

  initial begin
    axis.tready = 1'b0;
    test_reset();
    test_single();
    test_gaps();
    test_wrap();
    test_stall();
    test_stop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
